// File: rtl/o_mem_reader_pkg.sv
// Shared definitions for the output-memory read sequencer: FSM states,
// stream FIFO depth and the modulo address-increment helper.
package o_mem_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Depth 3 covers the two-cycle read pipeline plus the head word, so 4 gives margin.
  localparam int FD = 4;

  function automatic logic [31:0] wrap_inc(input logic [31:0] cur, input logic [31:0] depth);
    return (cur == depth - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/o_mem_rd_fifo.sv
// Small synchronous FIFO holding {data, last} words on their way to the stream port.
// Simultaneous push and pop are allowed, including when the FIFO is full.
module o_mem_rd_fifo
  import o_mem_reader_pkg::*;
#(
  parameter  int W  = 33,
  parameter  int N  = FD,
  localparam int PW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  store [N];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(N));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the stream data is clean without resetting storage.
  assign pop_data = empty ? '0 : store[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= PW'(wrap_inc(32'(wr_ptr), N));
      if (do_pop)  rd_ptr <= PW'(wrap_inc(32'(rd_ptr), N));
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage array has no reset; valid contents are tracked by the pointers
  // and count alone, which keeps this a plain RAM/register file.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/o_mem_reader.sv
// Read-side sequencer for the ANN output memory: issues COUNT wrapping reads,
// absorbs the 2-cycle read latency and streams words out with last tagging.
module o_mem_reader
  import o_mem_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int CW = $clog2(FD + 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr_ptr;
  logic [AW:0]   remaining;
  logic          p0;
  logic          p1;
  logic          tag0;
  logic          tag1;
  logic          issue;
  logic          pop;
  logic [CW:0]   credit_sum;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic [WIDTH:0] head;

  // Words already in flight hold a FIFO slot; a same-cycle pop earns no credit.
  always_comb begin
    credit_sum = {1'b0, fifo_cnt} + (CW + 1)'(p0) + (CW + 1)'(p1);
    issue      = (state == ST_RUN) && (remaining != '0)
                 && (credit_sum < (CW + 1)'(FD)) && !fifo_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = (count != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (issue && remaining == (AW + 1)'(1)) state_nx = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !p0 && !p1) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ptr  <= '0;
      remaining <= '0;
      mem_addr  <= '0;
      p0        <= 1'b0;
      p1        <= 1'b0;
      tag0      <= 1'b0;
      tag1      <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        addr_ptr  <= base;
        remaining <= count;
      end
      if (issue) begin
        mem_addr  <= addr_ptr;
        addr_ptr  <= AW'(wrap_inc(32'(addr_ptr), DEPTH));
        remaining <= remaining - (AW + 1)'(1);
      end
      p0   <= issue;
      tag0 <= issue && (remaining == (AW + 1)'(1));
      p1   <= p0;
      tag1 <= tag0;
    end
  end

  o_mem_rd_fifo #(
    .W (WIDTH + 1),
    .N (FD)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (p1),
    .push_data ({mem_rdata, tag1}),
    .pop       (pop),
    .pop_data  (head),
    .cnt       (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign pop     = m_valid && m_ready;
  assign m_valid = !fifo_empty;
  assign m_data  = head[WIDTH:1];
  assign m_last  = head[0];
  assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);
  assign mem_wr  = 1'b0;

endmodule

// File: tb/tb_o_mem_reader.sv
// Self-checking bench for o_mem_reader: registered-read memory model plus a
// queue-based reference of the expected word stream for each transfer.
module tb_o_mem_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 8;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base = '0;
  logic [AW:0]      count = '0;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_addr;
  logic             mem_wr;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;

  int passed = 0;
  int total  = 0;
  int last_addr = 0;

  o_mem_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] mem_word(input int k);
    return WIDTH'(k * 16 + 5);
  endfunction

  // Memory array registers its output on the edge after the address changes.
  always @(posedge clk) mem_rdata <= mem_word(int'(mem_addr) % DEPTH);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // mode 0: ready high; mode 1: random ready; mode 2: ready low 10 cycles after 2 pops
  task automatic run_transfer(input int b, input int n, input int mode, input string name);
    beat_t q[$];
    int c = 1;
    int first_c = -1;
    int last_pop_c = -1;
    int done_c = -1;
    int popped = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    for (int i = 0; i < n; i++) q.push_back('{mem_word((b + i) % DEPTH), (i == n - 1)});
    base  = AW'(b);
    count = (AW + 1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (c < 300) begin
      if (mode == 2 && popped == 2 && !stalled) begin
        stalled    = 1'b1;
        stall_left = 10;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (stall_left == 0);
      endcase
      if (q.size() != 0) check({name, " busy"}, busy, 1);
      if (m_valid) begin
        if (first_c < 0) first_c = c;
        if (q.size() == 0) begin
          check({name, " extra beat"}, m_valid, 0);
        end else begin
          check({name, " data"}, m_data, q[0].data);
          check({name, " last"}, m_last, q[0].last);
          if (m_ready) begin
            void'(q.pop_front());
            popped++;
            if (q.size() == 0) last_pop_c = c;
          end
        end
      end
      if (stall_left > 0) begin
        check({name, " valid in stall"}, m_valid, 1);
        stall_left--;
        if (stall_left == 0) check({name, " issued addr in stall"}, mem_addr, (b + 5) % DEPTH);
      end
      if (done) begin
        done_c = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    check({name, " words left"}, q.size(), 0);
    check({name, " done latency"}, done_c, last_pop_c + 2);
    if (mode == 0) begin
      check({name, " first valid latency"}, first_c - 1, 3);
      check({name, " back-to-back"}, last_pop_c - first_c, n - 1);
    end
    @(negedge clk);
    check({name, " done width"}, done, 0);
    check({name, " idle busy"}, busy, 0);
    last_addr = (b + n - 1) % DEPTH;
  endtask

  initial begin
    int pulses;
    int b;
    int n;

    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset valid", m_valid, 0);
    check("reset last", m_last, 0);
    check("reset data", m_data, 0);
    check("reset addr", mem_addr, 0);
    check("reset wr", mem_wr, 0);
    rst = 1'b0;
    @(negedge clk);

    run_transfer(0, 8, 0, "full");
    run_transfer(6, 4, 0, "wrap");

    // Zero-length transfer: single done pulse, no stream, no read issued.
    base  = 8'd3;
    count = '0;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) pulses++;
      check("zero valid", m_valid, 0);
      check("zero busy", busy, 0);
      @(negedge clk);
    end
    check("zero done pulses", pulses, 1);
    check("zero addr", mem_addr, last_addr);

    run_transfer(0, 8, 2, "stall");
    run_transfer(3, 8, 1, "random");
    for (int k = 0; k < 2; k++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, DEPTH));
      run_transfer(b, n, 1, "rand_len");
    end

    // Reset with three words buffered behind a stalled consumer.
    m_ready = 1'b0;
    base    = 8'd2;
    count   = 9'd8;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset valid", m_valid, 1);
    rst = 1'b1;
    #1;
    check("rst valid", m_valid, 0);
    check("rst busy", busy, 0);
    check("rst data", m_data, 0);
    check("rst addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_transfer(5, 3, 0, "after_rst");
    check("final wr", mem_wr, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
